// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch sequencer: owns the PC, issues one-outstanding fetches to
// instruction memory and turns jump/branch redirects into new fetch addresses.
module fetch_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        jump_reg_en_i,
   input  logic [31:0] jump_reg_i,
   input  logic        jump_en_i,
   input  logic [27:0] jump_target_i,
   input  logic        branch_en_i,
   input  logic [15:0] branch_offset_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o
);

   typedef enum logic [1:0] {HOLD, REQ, SQUASH} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;

   logic        redirect;
   logic [31:0] base;
   logic [31:0] branch_off;
   logic [31:0] target;

   always_comb begin
      base       = redirect_pc_i + 32'd4;
      branch_off = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
      redirect   = jump_reg_en_i | jump_en_i | branch_en_i;
      if (jump_reg_en_i)  target = jump_reg_i;
      else if (jump_en_i) target = {base[31:28], jump_target_i};
      else                target = base + branch_off;
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;

      if (valid_q && !stall_i) valid_d = 1'b0;

      unique case (state_q)
         HOLD: begin
            if (!redirect && (!valid_q || !stall_i)) begin
               state_d = REQ;
               addr_d  = pc_q;
            end
         end
         REQ: begin
            if (imem_ack_i) begin
               state_d = HOLD;
               if (!redirect) begin
                  instr_d    = imem_data_i;
                  instr_pc_d = addr_q;
                  valid_d    = 1'b1;
                  pc_d       = addr_q + 32'd4;
               end
            end else if (redirect) begin
               state_d = SQUASH;
            end
         end
         SQUASH: begin
            // The stale fetch must still complete before the bus is reused.
            if (imem_ack_i) state_d = HOLD;
         end
         default: state_d = HOLD;
      endcase

      if (redirect) begin
         pc_d    = target;
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= HOLD;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= 32'h0;
         instr_pc_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   assign imem_req_o    = (state_q == REQ) || (state_q == SQUASH);
   assign imem_addr_o   = addr_q;
   assign instr_valid_o = valid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;

endmodule
